aes_key_schedule: RTL

Sequential AES key expansion that turns a cipher key into the full round-key vector consumed by the iterative AES decrypt and encrypt cores. It generates one 32-bit schedule word per clock from a sliding window of the last Nk words, then holds the packed result stable with a valid flag. It replaces the purely combinational expansion feeding the cores, trading about 40 cycles of latency for one shared 4-byte S-box path.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_key_schedule_if.sv | 42 ++++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_key_schedule.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions used by the key schedule and the cipher
// cores. Holds the forward S-box table, the GF(2^8) helper functions, the
// key-schedule FSM state type and the common word/block widths.
package aes_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ks_state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255-x)*8, and 255-x is simply ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// aes_key_schedule_if: request/result bundle between a key-schedule client
// and the key schedule. The master drives start/key, the slave (the key
// schedule) returns busy/valid and the packed round keys.
// Optional macro KEY_SCHED_ZEROIZE_EN adds the zeroize request line.
interface aes_key_schedule_if
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
);

  logic                        start;
  logic [WORD_W*Nk-1:0]        key;
  logic                        busy;
  logic                        valid;
  logic [BLOCK_W*(Nr+1)-1:0]   all_keys;

`ifdef KEY_SCHED_ZEROIZE_EN
  logic                        zeroize;

  modport master (
    output start, key, zeroize,
    input  busy, valid, all_keys
  );

  modport slave (
    input  start, key, zeroize,
    output busy, valid, all_keys
  );
`else
  modport master (
    output start, key,
    input  busy, valid, all_keys
  );

  modport slave (
    input  start, key,
    output busy, valid, all_keys
  );
`endif

endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: SubWord for the key schedule, four parallel S-box lookups
// on a 32-bit word. Purely combinational; one instance is shared by the
// RotWord path and the Nk=8 mid-window path.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sub
);

  // Substitute each byte independently through the S-box.
  always_comb begin
    sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
  end

endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES key expansion. Loads Nk key words, then
// produces one schedule word per clock from a sliding window of the last
// Nk words until all 4*(Nr+1) words are written, then holds the packed
// round keys with valid high. Nk must be 4, 6 or 8 and Nr must be Nk+6.
// Optional macro KEY_SCHED_ZEROIZE_EN adds a zeroize request that wipes
// all key material and returns to IDLE in one cycle.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
)
(
  input logic clk,
  input logic rst,
  aes_key_schedule_if.slave bus
);

  localparam int         NWORDS    = 4 * (Nr + 1);
  localparam logic [5:0] LAST_IDX  = 6'(NWORDS - 1);
  localparam logic [5:0] FIRST_IDX = 6'(Nk);
  localparam logic [2:0] LAST_PH   = 3'(Nk - 1);

  ks_state_t                  state;
  ks_state_t                  state_next;
  logic [WORD_W-1:0]          window [Nk];
  logic [5:0]                 idx;
  logic [2:0]                 phase;
  logic [7:0]                 rcon;
  logic [BLOCK_W*(Nr+1)-1:0]  all_keys_q;

  logic                       load;
  logic                       step;
  logic                       clear;
  logic                       zeroize_req;

  logic [WORD_W-1:0]          w_prev;
  logic [WORD_W-1:0]          sub_in;
  logic [WORD_W-1:0]          sub_out;
  logic [WORD_W-1:0]          temp;
  logic [WORD_W-1:0]          w_new;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zeroize_req = bus.zeroize;
`else
  assign zeroize_req = 1'b0;
`endif

  // The newest window word feeds the transform; RotWord only on the rcon step.
  assign w_prev = window[Nk-1];
  assign sub_in = (phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  // Select the transform t for the current position and form w[i].
  always_comb begin
    temp = w_prev;
    if (phase == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h000000};
    end else if ((Nk == 8) && (phase == 3'd4)) begin
      temp = sub_out;
    end
    w_new = window[0] ^ temp;
  end

  // State register; reset returns to IDLE regardless of other requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes; zeroize overrides start in every state.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    clear      = 1'b0;
    if (zeroize_req) begin
      clear      = 1'b1;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            load       = 1'b1;
            state_next = EXPAND;
          end
        end
        EXPAND: begin
          step = 1'b1;
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (bus.start) begin
            load       = 1'b1;
            state_next = EXPAND;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Window, index, rcon and the packed key vector; unwritten words hold on restart.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      all_keys_q <= '0;
      for (int j = 0; j < Nk; j++) begin
        window[j] <= '0;
      end
      idx   <= '0;
      phase <= '0;
      rcon  <= 8'h01;
    end else if (load) begin
      for (int j = 0; j < Nk; j++) begin
        window[j] <= bus.key[WORD_W*(Nk-j)-1 -: WORD_W];
        all_keys_q[(j/4)*BLOCK_W + BLOCK_W-1 - WORD_W*(j%4) -: WORD_W]
          <= bus.key[WORD_W*(Nk-j)-1 -: WORD_W];
      end
      idx   <= FIRST_IDX;
      phase <= '0;
      rcon  <= 8'h01;
    end else if (step) begin
      for (int j = 0; j < Nk-1; j++) begin
        window[j] <= window[j+1];
      end
      window[Nk-1] <= w_new;
      for (int n = 0; n < NWORDS; n++) begin
        if (idx == 6'(n)) begin
          all_keys_q[(n/4)*BLOCK_W + BLOCK_W-1 - WORD_W*(n%4) -: WORD_W] <= w_new;
        end
      end
      idx   <= idx + 6'd1;
      phase <= (phase == LAST_PH) ? 3'd0 : phase + 3'd1;
      if (phase == 3'd0) begin
        rcon <= xtime(rcon);
      end
    end
  end

  assign bus.busy     = (state == EXPAND);
  assign bus.valid    = (state == DONE);
  assign bus.all_keys = all_keys_q;

endmodule
